// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard unit: per-register load scoreboard for load-use stalls,
// branch resolution at decode and a flush FSM. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS    = 8,
    parameter int OPC_W       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter logic [OPC_W-1:0] OPC_JZ  = 5'h18,
    parameter logic [OPC_W-1:0] OPC_JN  = 5'h19,
    parameter logic [OPC_W-1:0] OPC_JC  = 5'h1A,
    parameter logic [OPC_W-1:0] OPC_JMP = 5'h1B,
    localparam int REG_W = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [OPC_W-1:0] dec_opcode,
    input  logic [REG_W-1:0] dec_src1,
    input  logic             dec_use1,
    input  logic [REG_W-1:0] dec_src2,
    input  logic             dec_use2,
    input  logic [REG_W-1:0] dec_dst,
    input  logic             dec_mem_rd,
    input  logic [3:0]       ccr,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt,
`endif
    output logic             stall,
    output logic             flush_if,
    output logic [1:0]       pc_src
);

    localparam int CW  = $clog2(LOAD_LAT + 1);
    localparam int FCW = 3;

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_FLUSH} state_e;

    state_e               state_q, state_d;
    logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
    logic [NUM_REGS-1:0]  pend;
    logic                 in_flush, hit, stall_w, issue, br_cond, taken;
    logic                 unused_ccr_of;

    assign unused_ccr_of = ccr[2];

    assign in_flush = (state_q == S_FLUSH);
    assign hit      = dec_valid & ((dec_use1 & pend[dec_src1]) | (dec_use2 & pend[dec_src2]));
    assign stall_w  = hit & ~in_flush;
    assign issue    = dec_valid & dec_mem_rd & ~stall_w & ~in_flush;
    assign br_cond  = (dec_opcode == OPC_JMP)
                    | ((dec_opcode == OPC_JZ) & ccr[0])
                    | ((dec_opcode == OPC_JN) & ccr[3])
                    | ((dec_opcode == OPC_JC) & ccr[1]);
    assign taken    = dec_valid & ~stall_w & ~in_flush & br_cond;
    assign stall    = stall_w;

    // One down-counter per register; a fresh load overrides the decrement.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (issue && (dec_dst == REG_W'(gi))) begin
                    cnt_d = CW'(LOAD_LAT);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign pend[gi] = (cnt_q != '0);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        flush_if    = 1'b0;
        pc_src      = 2'b00;
        case (state_q)
            S_IDLE, S_STALL: begin
                if (stall_w) begin
                    pc_src  = 2'b10;
                    state_d = S_STALL;
                end else if (taken) begin
                    pc_src      = 2'b01;
                    flush_if    = 1'b1;
                    flush_cnt_d = FCW'(FLUSH_DEPTH - 1);
                    state_d     = (FLUSH_DEPTH > 1) ? S_FLUSH : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                // flush_cnt holds the flush cycles still to come, including this one
                flush_if    = 1'b1;
                flush_cnt_d = (flush_cnt_q != '0) ? flush_cnt_q - 1'b1 : '0;
                if (flush_cnt_q <= FCW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_w && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_if && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two configurations (LOAD_LAT=1/FLUSH_DEPTH=2 and
// LOAD_LAT=3/FLUSH_DEPTH=1) share one stimulus stream and are checked against a ready-time model.
module tb_hazard_scoreboard_unit;

    localparam logic [4:0] OP_ADD = 5'h01, OP_LDD = 5'h0C, OP_POP = 5'h0D;
    localparam logic [4:0] OP_JZ  = 5'h18, OP_JN  = 5'h19, OP_JC  = 5'h1A, OP_JMP = 5'h1B;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_use1, dec_use2, dec_mem_rd;
    logic [4:0] dec_opcode;
    logic [2:0] dec_src1, dec_src2, dec_dst;
    logic [3:0] ccr;
    logic       stall_a, flush_a, stall_b, flush_b;
    logic [1:0] pc_a, pc_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] pst_a, pfl_a, pst_b, pfl_b;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(
        .NUM_REGS(8), .OPC_W(5), .LOAD_LAT(1), .FLUSH_DEPTH(2),
        .OPC_JZ(OP_JZ), .OPC_JN(OP_JN), .OPC_JC(OP_JC), .OPC_JMP(OP_JMP)
    ) u_dut_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_src1(dec_src1), .dec_use1(dec_use1), .dec_src2(dec_src2), .dec_use2(dec_use2),
        .dec_dst(dec_dst), .dec_mem_rd(dec_mem_rd), .ccr(ccr),
`ifdef HAZ_PERF_CNT_EN
        .perf_stall_cnt(pst_a), .perf_flush_cnt(pfl_a),
`endif
        .stall(stall_a), .flush_if(flush_a), .pc_src(pc_a)
    );

    hazard_scoreboard_unit #(
        .NUM_REGS(8), .OPC_W(5), .LOAD_LAT(3), .FLUSH_DEPTH(1),
        .OPC_JZ(OP_JZ), .OPC_JN(OP_JN), .OPC_JC(OP_JC), .OPC_JMP(OP_JMP)
    ) u_dut_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_src1(dec_src1), .dec_use1(dec_use1), .dec_src2(dec_src2), .dec_use2(dec_use2),
        .dec_dst(dec_dst), .dec_mem_rd(dec_mem_rd), .ccr(ccr),
`ifdef HAZ_PERF_CNT_EN
        .perf_stall_cnt(pst_b), .perf_flush_cnt(pfl_b),
`endif
        .stall(stall_b), .flush_if(flush_b), .pc_src(pc_b)
    );

    typedef struct {
        string      tag;
        int         k;
        logic [3:0] exp;   // {stall, flush_if, pc_src}
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ll[2]    = '{1, 3};
    int   fd[2]    = '{2, 1};
    int   ready[2][8];
    int   flush_left[2];
    int   perf_st[2];
    int   perf_fl[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One decode cycle: drive, predict, compare at negedge, advance past the next posedge.
    task automatic step(input string tag, input logic r, input logic v, input logic [4:0] opc,
                        input logic [2:0] s1, input logic u1, input logic [2:0] s2, input logic u2,
                        input logic [2:0] d, input logic mrd, input logic [3:0] c);
        logic       hit, st, tk, in_fl, br;
        logic [3:0] got;
        exp_t       e;
        rst = r; dec_valid = v; dec_opcode = opc; dec_src1 = s1; dec_use1 = u1;
        dec_src2 = s2; dec_use2 = u2; dec_dst = d; dec_mem_rd = mrd; ccr = c;
        for (int k = 0; k < 2; k++) begin
            if (r) continue;
            in_fl = (flush_left[k] > 0);
            hit   = v && ((u1 && cyc < ready[k][s1]) || (u2 && cyc < ready[k][s2]));
            st    = hit && !in_fl;
            br    = (opc == OP_JMP) || (opc == OP_JZ && c[0]) || (opc == OP_JN && c[3])
                 || (opc == OP_JC && c[1]);
            tk    = v && !st && !in_fl && br;
            e.tag = $sformatf("%s/%s", tag, (k == 0) ? "a" : "b");
            e.k   = k;
            e.exp = {st, in_fl || tk, st ? 2'b10 : (tk ? 2'b01 : 2'b00)};
            q.push_back(e);
        end
        @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
        if (!r) begin
            check_eq({tag, "/pst_a"}, pst_a, perf_st[0]);
            check_eq({tag, "/pfl_a"}, pfl_a, perf_fl[0]);
            check_eq({tag, "/pst_b"}, pst_b, perf_st[1]);
            check_eq({tag, "/pfl_b"}, pfl_b, perf_fl[1]);
        end
`endif
        while (q.size() > 0) begin
            e   = q.pop_front();
            got = (e.k == 0) ? {stall_a, flush_a, pc_a} : {stall_b, flush_b, pc_b};
            check_eq(e.tag, {28'd0, got}, {28'd0, e.exp});
            if (e.exp[3]) perf_st[e.k]++;
            if (e.exp[2]) perf_fl[e.k]++;
        end
        $display("[%0d] %-12s rst=%b v=%b op=%h a:st=%b fl=%b pc=%b b:st=%b fl=%b pc=%b",
                 cyc, tag, r, v, opc, stall_a, flush_a, pc_a, stall_b, flush_b, pc_b);
        // advance the model state for the coming edge
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                for (int i = 0; i < 8; i++) ready[k][i] = 0;
                flush_left[k] = 0;
                perf_st[k] = 0;
                perf_fl[k] = 0;
                continue;
            end
            in_fl = (flush_left[k] > 0);
            hit   = v && ((u1 && cyc < ready[k][s1]) || (u2 && cyc < ready[k][s2]));
            st    = hit && !in_fl;
            br    = (opc == OP_JMP) || (opc == OP_JZ && c[0]) || (opc == OP_JN && c[3])
                 || (opc == OP_JC && c[1]);
            tk    = v && !st && !in_fl && br;
            if (v && mrd && !st && !in_fl) ready[k][d] = cyc + ll[k] + 1;
            if (in_fl) flush_left[k]--;
            else if (tk) flush_left[k] = fd[k] - 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b0, 1'b0, OP_ADD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            flush_left[k] = 0;
            perf_st[k] = 0;
            perf_fl[k] = 0;
            for (int i = 0; i < 8; i++) ready[k][i] = 0;
        end
        step("reset", 1'b1, 1'b0, OP_ADD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0);
        step("reset", 1'b1, 1'b0, OP_ADD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0);
        nop("idle");

        // load-use on R3
        step("ldd_r3", 1'b0, 1'b1, OP_LDD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++)
            step("add_r3", 1'b0, 1'b1, OP_ADD, 3'd3, 1'b1, 3'd2, 1'b1, 3'd1, 1'b0, 4'd0);

        // POP R5, consumer of R5, then unrelated consumer of R4
        step("pop_r5", 1'b0, 1'b1, OP_POP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++)
            step("use_r5", 1'b0, 1'b1, OP_ADD, 3'd1, 1'b1, 3'd5, 1'b1, 3'd6, 1'b0, 4'd0);
        step("pop_r5b", 1'b0, 1'b1, OP_POP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 4'd0);
        step("use_r4", 1'b0, 1'b1, OP_ADD, 3'd4, 1'b1, 3'd0, 1'b0, 3'd6, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) nop("drain");

        // conditional branches
        step("jz_t", 1'b0, 1'b1, OP_JZ, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'b0001);
        nop("shadow");
        nop("after");
        step("jz_nt", 1'b0, 1'b1, OP_JZ, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'b0000);
        step("jn_t", 1'b0, 1'b1, OP_JN, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'b1000);
        nop("shadow");
        step("jc_t", 1'b0, 1'b1, OP_JC, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'b0010);
        nop("shadow");
        step("jc_nt", 1'b0, 1'b1, OP_JC, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'b1101);

        // JMP through a pending register
        step("ldd_r2", 1'b0, 1'b1, OP_LDD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++)
            step("jmp_r2", 1'b0, 1'b1, OP_JMP, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0);
        nop("drain");
        nop("drain");

        // re-arm a pending register
        step("ldd_r6", 1'b0, 1'b1, OP_LDD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 4'd0);
        step("ldd_r6b", 1'b0, 1'b1, OP_LDD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++)
            step("use_r6", 1'b0, 1'b1, OP_ADD, 3'd6, 1'b1, 3'd0, 1'b0, 3'd7, 1'b0, 4'd0);

        // load in the flush shadow
        step("jmp", 1'b0, 1'b1, OP_JMP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0);
        step("ldd_r1_sh", 1'b0, 1'b1, OP_LDD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++)
            step("use_r1", 1'b0, 1'b1, OP_ADD, 3'd0, 1'b0, 3'd1, 1'b1, 3'd2, 1'b0, 4'd0);

        // reset in the middle of a stall
        step("pop_r5c", 1'b0, 1'b1, OP_POP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 4'd0);
        step("use_r5c", 1'b0, 1'b1, OP_ADD, 3'd5, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 4'd0);
        step("rst_mid", 1'b1, 1'b1, OP_ADD, 3'd5, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 4'd0);
        step("post_rst", 1'b0, 1'b1, OP_ADD, 3'd5, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 4'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            logic [4:0] opc;
            int         sel;
            sel = $urandom_range(7);
            case (sel)
                0: opc = OP_JZ;
                1: opc = OP_JN;
                2: opc = OP_JC;
                3: opc = OP_JMP;
                4: opc = OP_LDD;
                default: opc = OP_ADD;
            endcase
            step("rand", ($urandom_range(79) == 0), ($urandom_range(5) != 0), opc,
                 3'($urandom_range(7)), 1'($urandom), 3'($urandom_range(7)), 1'($urandom),
                 3'($urandom_range(7)), ($urandom_range(3) == 0), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
